// File: rtl/div_pkg.sv
// Shared constants and state type for the sequential restoring divider.
package div_pkg;

    localparam int DEF_DW = 8;
    localparam int CNT_W = $clog2(2 * DEF_DW);
    localparam logic [2*DEF_DW-1:0] Q_ALL_ONES = '1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits, and emit the resolved quotient bit.
module div_step #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] r,
    input  logic          din,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] r_next,
    output logic          q_bit
);

    logic [DW:0] r_shift;

    assign r_shift = {r, din};
    assign q_bit   = (r_shift >= {1'b0, divisor});

    // The restored value is always below the divisor, so DW-bit wraparound
    // arithmetic gives the exact difference.
    assign r_next = q_bit ? (r_shift[DW-1:0] - divisor) : r_shift[DW-1:0];

endmodule

// File: rtl/divider16by8_seq.sv
// Sequential restoring divider, 2*DW / DW, one quotient bit per clock.
// Optional result self-check: DIVIDER16BY8_SELFCHECK_EN.
module divider16by8_seq
    import div_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] quotient,
    output logic [DW-1:0]   remainder,
    output logic            div_by_zero
`ifdef DIVIDER16BY8_SELFCHECK_EN
    ,
    output logic            check_err
`endif
);

    localparam int CW = (DW == DEF_DW) ? CNT_W : $clog2(2 * DW);
    localparam logic [2*DW-1:0] Q_DBZ =
        (DW == DEF_DW) ? (2*DW)'(Q_ALL_ONES) : {2*DW{1'b1}};

    div_state_t      state;
    logic [2*DW-1:0] dvd_sh;
    logic [DW-1:0]   dsr;
    logic [DW-1:0]   r;
    logic [2*DW-1:0] q_sh;
    logic [CW-1:0]   cnt;

    logic [DW-1:0]   r_nxt;
    logic            q_bit;
    logic [2*DW-1:0] q_fin;
    logic            last_step;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign q_fin     = {q_sh[2*DW-2:0], q_bit};
    assign last_step = (state == BUSY) && (cnt == '0);

    div_step #(
        .DW(DW)
    ) u_step (
        .r      (r),
        .din    (dvd_sh[2*DW-1]),
        .divisor(dsr),
        .r_next (r_nxt),
        .q_bit  (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dvd_sh      <= '0;
            dsr         <= '0;
            r           <= '0;
            q_sh        <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (divisor != '0) begin
                            dvd_sh <= dividend;
                            dsr    <= divisor;
                            r      <= '0;
                            q_sh   <= '0;
                            cnt    <= CW'(2 * DW - 1);
                            state  <= BUSY;
                        end else begin
                            quotient    <= Q_DBZ;
                            remainder   <= dividend[DW-1:0];
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                BUSY: begin
                    dvd_sh <= dvd_sh << 1;
                    r      <= r_nxt;
                    q_sh   <= q_fin;
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) begin
                        quotient    <= q_fin;
                        remainder   <= r_nxt;
                        div_by_zero <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DIVIDER16BY8_SELFCHECK_EN
    logic [2*DW-1:0] dvd_lat;
    logic [3*DW-1:0] recon;
    logic            chk_bad;

    // Rebuild the dividend from the result that is about to be loaded.
    assign recon = (3*DW)'(q_fin) * (3*DW)'(dsr) + (3*DW)'(r_nxt);
    assign chk_bad = (recon != (3*DW)'(dvd_lat)) || (r_nxt >= dsr);

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_lat   <= '0;
            check_err <= 1'b0;
        end else begin
            if (in_ready && in_valid && divisor != '0) dvd_lat <= dividend;
            if (last_step && chk_bad) check_err <= 1'b1;
        end
    end
`else
    logic unused_last;
    assign unused_last = last_step;
`endif

endmodule

// File: doc/divider16by8_seq.md
Name: divider16by8_seq

Overview:
- Sequential restoring divider. Inverse datapath of the 8x8 multiplier family: divides a 2*DW-bit product-width dividend by a DW-bit divisor.
- Produces an exact quotient and remainder.
- Serves as the golden inverse for multiplier error characterisation and the DSP divide path.
- Valid/ready on input and output; one quotient bit resolved per clock.

Parameters:
DW, 8, divisor/remainder width; dividend and quotient are 2*DW bits

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
dividend  input  2*DW  numerator
divisor  input  DW  denominator
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
quotient  output  2*DW  floor(dividend/divisor)
remainder  output  DW  dividend mod divisor
div_by_zero  output  1  divisor was zero for this result

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; in_ready=1; out_valid=0; quotient=0; remainder=0; div_by_zero=0. Reset mid-operation aborts the operation and discards the result.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready:
    - divisor!=0: latch operands; clear partial remainder (DW+1 bits); set cnt=2*DW-1; go to BUSY.
    - divisor==0: quotient={2*DW{1}}, remainder=dividend[DW-1:0], div_by_zero=1; go to DONE.
  - BUSY: in_ready=0. Each cycle:
    - r' = {r[DW-1:0], dividend_shift[MSB]}.
    - If r' >= {1'b0,divisor}: r = r' - divisor and shift quotient bit 1; else r = r' and shift 0.
    - Decrement cnt. When the cnt==0 step completes, go to DONE.
  - DONE: out_valid=1; outputs held stable while out_ready=0. On out_ready, go to IDLE; out_valid falls the next cycle.
- Latency, with the accept edge at cycle T:
  - Normal: out_valid first high in cycle T+2*DW+1 (T+17 for DW=8).
  - Divide-by-zero: out_valid first high in cycle T+1.
- Throughput: one operation per 2*DW+2 cycles minimum. in_ready is low in DONE; there is no overlap.
- in_valid while not in_ready is ignored. Operands are sampled only at the accept edge, so later changes have no effect.
- quotient, remainder and div_by_zero change only when DONE is entered or on reset. div_by_zero clears when the next result is loaded.
- Arithmetic is unsigned only. The remainder is always < divisor.

Optional Feature:
- Macro: DIVIDER16BY8_SELFCHECK_EN.
- Defined:
  - Adds output port check_err (1 bit), reset 0.
  - On entering DONE with a non-zero divisor, compute quotient*divisor+remainder with an exact multiplier and compare it to the latched dividend. Set check_err=1 on mismatch; it is sticky until rst.
  - check_err is also set if remainder>=divisor.
- Undefined: no check_err port and no multiplier logic. Behaviour is otherwise identical.

Decomposition:
- Package div_pkg holds:
  - DW default constant.
  - State typedef div_state_t {IDLE, BUSY, DONE}.
  - Counter width constant CNT_W = $clog2(2*DW).
  - All-ones quotient constant for divide-by-zero.
- One sub-module, div_step: a combinational single restoring step.
  - Inputs: r, next dividend bit, divisor.
  - Outputs: new r, quotient bit.
  - The top instantiates it once and holds the FSM, counter and registers.

Test Plan:
- 1000 / 7, out_ready=1: out_valid exactly 17 cycles after accept; quotient=142, remainder=6, div_by_zero=0.
- 65535 / 255 gives q=257, r=0. Then 65535 / 1 gives q=65535, r=0. Then 100 / 200 gives q=0, r=100. All back-to-back, with in_ready low from accept until the cycle after the out handshake.
- 5 / 0: out_valid 1 cycle after accept; quotient=0xFFFF, remainder=5, div_by_zero=1. The next 9 / 3 gives q=3, r=0, div_by_zero=0.
- 40000 / 123 with out_ready held 0 for 5 cycles after out_valid: q=325, r=25 held stable and out_valid stays 1; in_valid pulses in DONE are not accepted.
- rst asserted at cycle 8 of BUSY: next cycle in_ready=1, out_valid=0, outputs 0. A following 12 / 4 gives q=3, r=0.
- With DIVIDER16BY8_SELFCHECK_EN, 2000 random non-zero-divisor operations: check_err stays 0 and every result matches the reference model.
